uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter_if.sv | 11 +
 rtl/uart_transmitter.sv | 129 ++++++++++++
 tb/tb_uart_transmitter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - byte write / serial line bundle between host and uart_transmitter
interface uart_transmitter_if;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       TxD;
  logic       Tx_BUSY;

  modport master (output Tx_EN, Tx_WR, Tx_DATA, input TxD, Tx_BUSY);
  modport slave  (input Tx_EN, Tx_WR, Tx_DATA, output TxD, Tx_BUSY);
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - oversampled UART transmitter, 8N1; define UART_PARITY_EN for 8E1
module uart_transmitter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               baud_tick,
  uart_transmitter_if.slave  bus
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] tick_cnt, tick_cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;
  logic          txd, txd_next;
  logic          busy, busy_next;
  logic          accept;
  logic          bit_done;
`ifdef UART_PARITY_EN
  logic          parity, parity_next;
`endif

  assign accept   = bus.Tx_WR & bus.Tx_EN & ~busy;
  assign bit_done = baud_tick & (tick_cnt == TICK_LAST);

  assign bus.TxD     = txd;
  assign bus.Tx_BUSY = busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      txd      <= txd_next;
      busy     <= busy_next;
`ifdef UART_PARITY_EN
      parity   <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_START;
      S_START:  if (bit_done) state_next = S_DATA;
      S_DATA: begin
        if (bit_done && bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (bit_done) state_next = S_STOP;
`endif
      S_STOP:   if (bit_done) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Counter only runs inside a frame, so a tick coinciding with acceptance is not counted.
  always_comb begin
    tick_cnt_next = tick_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
`ifdef UART_PARITY_EN
    parity_next   = parity;
`endif
    if (state_next != state || bit_done) begin
      tick_cnt_next = '0;
    end else if (baud_tick && state != S_IDLE) begin
      tick_cnt_next = tick_cnt + 1'b1;
    end

    if (state == S_IDLE && accept) begin
      shift_next   = bus.Tx_DATA;
      bit_idx_next = 3'd0;
`ifdef UART_PARITY_EN
      parity_next  = ^bus.Tx_DATA;
`endif
    end else if (state == S_DATA && bit_done && bit_idx != 3'd7) begin
      shift_next   = {1'b0, shift[7:1]};
      bit_idx_next = bit_idx + 3'd1;
    end
  end

  // Outputs are decoded from next-state values so TxD and Tx_BUSY stay registered.
  always_comb begin
    txd_next  = 1'b1;
    busy_next = (state_next != S_IDLE);
    case (state_next)
      S_START:  txd_next = 1'b0;
      S_DATA:   txd_next = shift_next[0];
`ifdef UART_PARITY_EN
      S_PARITY: txd_next = parity_next;
`endif
      S_STOP:   txd_next = 1'b1;
      default:  txd_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - randomized self-checking bench for uart_transmitter
module tb_uart_transmitter;

  localparam int OS = 16;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  logic reset;
  logic baud_tick = 1'b0;
  bit   rand_ticks = 1'b0;

  uart_transmitter_if bus ();

  uart_transmitter #(.OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  logic samples[$];
  logic exp_q[$];
  int   busy_cnt = 0;
  int   idle_cnt = 0;
  int   low_cnt  = 0;

  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rand_ticks) baud_tick = ($urandom_range(0, 2) == 0);
      else            baud_tick = (phase == 3);
      phase = (phase + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (bus.Tx_BUSY === 1'b1 && baud_tick) samples.push_back(bus.TxD);
    if (bus.Tx_BUSY === 1'b1) busy_cnt++;
    else idle_cnt++;
    if (bus.TxD !== 1'b1) low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start, data LSB first, optional even parity, stop.
  task automatic add_frame(input logic [7:0] d);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(1'((d >> i) & 8'd1));
      ones += int'((d >> i) & 8'd1);
    end
`ifdef UART_PARITY_EN
    exp_q.push_back(1'(ones % 2));
`endif
    exp_q.push_back(1'b1);
  endtask

  task automatic compare_frames(input string tag, input int start);
    logic obs;
    int   idx;
    check({tag, " ticks"}, samples.size() - start, exp_q.size() * OS);
    for (int b = 0; b < exp_q.size(); b++) begin
      obs = exp_q[b];
      for (int k = 0; k < OS; k++) begin
        idx = start + b * OS + k;
        if (idx >= samples.size()) obs = 1'bx;
        else if (samples[idx] !== exp_q[b]) obs = samples[idx];
      end
      check($sformatf("%s bit%0d", tag, b), {31'd0, obs}, {31'd0, exp_q[b]});
    end
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.Tx_BUSY === 1'b1 && n < BUDGET) begin
      @(posedge clk);
      #3;
      n++;
    end
    check({tag, " timeout"}, n < BUDGET, 1);
  endtask

  task automatic wait_samples(input int target, input string tag);
    int n;
    n = 0;
    while (samples.size() < target && n < BUDGET) begin
      @(posedge clk);
      #3;
      n++;
    end
    check({tag, " wait"}, n < BUDGET, 1);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit aligned, input string tag);
    int n;
    n = 0;
    while (aligned && !baud_tick && n < 16) begin
      @(posedge clk);
      #3;
      n++;
    end
    bus.Tx_DATA = d;
    bus.Tx_WR   = 1'b1;
    @(posedge clk);
    #3;
    bus.Tx_WR   = 1'b0;
    bus.Tx_DATA = 8'($urandom);
    check({tag, " start latency TxD"}, bus.TxD, 0);
    check({tag, " start latency busy"}, bus.Tx_BUSY, 1);
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    int start;
    start = samples.size();
    write_byte(d, 1'b0, tag);
    wait_idle(tag);
    add_frame(d);
    compare_frames(tag, start);
  endtask

  initial begin
    int start, b0, l0, i0;
    logic [7:0] d;

    reset       = 1'b0;
    bus.Tx_EN   = 1'b0;
    bus.Tx_WR   = 1'b0;
    bus.Tx_DATA = 8'h00;
    repeat (3) @(posedge clk);
    #3;
    check("reset TxD", bus.TxD, 1);
    check("reset busy", bus.Tx_BUSY, 0);
    reset     = 1'b1;
    bus.Tx_EN = 1'b1;
    repeat (2) @(posedge clk);
    #3;

    // Regular ticks every 4 clk, write on a tick edge: exact 64 clk per bit.
    start = samples.size();
    b0 = busy_cnt;
    write_byte(8'h55, 1'b1, "x55");
    wait_idle("x55");
    check("x55 busy clk", busy_cnt - b0, NBITS * OS * 4);
    add_frame(8'h55);
    compare_frames("x55", start);

    rand_ticks = 1'b1;
    send(8'h07, "x07");
    send(8'h03, "x03");
    for (int r = 0; r < 4; r++) begin
      d = 8'($urandom);
      send(d, $sformatf("rand%0d", r));
    end

    bus.Tx_EN = 1'b0;
    bus.Tx_WR = 1'b1;
    bus.Tx_DATA = 8'h00;
    b0 = busy_cnt;
    l0 = low_cnt;
    repeat (50) begin
      @(posedge clk);
      #3;
    end
    bus.Tx_WR = 1'b0;
    check("disabled busy", busy_cnt - b0, 0);
    check("disabled TxD low", low_cnt - l0, 0);
    bus.Tx_EN = 1'b1;

    start = samples.size();
    write_byte(8'hA5, 1'b0, "xA5");
    wait_samples(start + 50, "xA5");
    bus.Tx_DATA = 8'hFF;
    bus.Tx_WR   = 1'b1;
    @(posedge clk);
    #3;
    bus.Tx_WR   = 1'b0;
    wait_idle("xA5");
    add_frame(8'hA5);
    compare_frames("xA5", start);
    check("xA5 no follow-on", bus.Tx_BUSY, 0);

    start = samples.size();
    write_byte(8'h3C, 1'b0, "x3C");
    wait_samples(start + 70, "x3C");
    bus.Tx_EN = 1'b0;
    wait_idle("x3C");
    add_frame(8'h3C);
    compare_frames("x3C", start);
    bus.Tx_EN = 1'b1;

    start = samples.size();
    write_byte(8'h18, 1'b0, "x18");
    i0 = idle_cnt;
    wait_idle("x18");
    write_byte(8'h81, 1'b0, "x81");
    wait_idle("x81");
    check("b2b idle clk", idle_cnt - i0, 1);
    add_frame(8'h18);
    add_frame(8'h81);
    compare_frames("b2b", start);

    start = samples.size();
    write_byte(8'hF0, 1'b0, "xF0");
    wait_samples(start + 5 * OS + OS / 2, "xF0");
    check("xF0 mid bit4 TxD", bus.TxD, 1);
    reset = 1'b0;
    #1;
    check("async reset TxD", bus.TxD, 1);
    check("async reset busy", bus.Tx_BUSY, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    b0 = busy_cnt;
    l0 = low_cnt;
    repeat (200) begin
      @(posedge clk);
      #3;
    end
    check("no resume busy", busy_cnt - b0, 0);
    check("no resume TxD low", low_cnt - l0, 0);

    d = 8'($urandom);
    send(d, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
